// File: rtl/shift_add_mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Optional zero-operand bypass is enabled by defining SHIFT_ADD_MUL_ZERO_BYPASS_EN.
package shift_add_mul_pkg;

    // Controller states: waiting for operands, iterating, holding the product
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter width; wide enough to hold WIDTH itself without wrapping
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_mul_rca.sv
// Ripple-carry adder used for the partial-product accumulate step.
module RippleCarryAdder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    // Bit-serial carry chain; a local carry variable keeps the chain acyclic
    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier: one conditional add + right shift per cycle,
// WIDTH iterations per product, valid/ready handshakes on both sides.
// Define SHIFT_ADD_MUL_ZERO_BYPASS_EN to skip the iterations when an operand is zero.
module shift_add_mul
    import shift_add_mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod
);

    localparam int CW = cnt_w(WIDTH);

    state_e             state, state_n;
    logic [2*WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0]   mcand, mcand_n;
    logic [CW-1:0]      cnt, cnt_n;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               co;

    // Multiplicand only contributes when the current multiplier bit is set
    assign addend = acc[0] ? mcand : '0;

    RippleCarryAdder #(.WIDTH(WIDTH)) u_add (
        .a  (acc[2*WIDTH-1:WIDTH]),
        .b  (addend),
        .ci (1'b0),
        .s  (sum),
        .co (co)
    );

    // Product is taken straight from the accumulator so it stays stable in DONE
    assign out_prod = acc;

    // State and datapath registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            mcand <= mcand_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state, datapath update and handshake outputs
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        mcand_n   = mcand;
        cnt_n     = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_n = in_a;
                    acc_n   = {{WIDTH{1'b0}}, in_b};
                    cnt_n   = '0;
                    state_n = RUN;
`ifdef SHIFT_ADD_MUL_ZERO_BYPASS_EN
                    if (in_a == '0 || in_b == '0) begin
                        acc_n   = '0;
                        state_n = DONE;
                    end
`endif
                end
            end
            RUN: begin
                // Carry-out becomes the new MSB; the consumed multiplier bit drops off
                acc_n = {co, sum, acc[WIDTH-1:1]};
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1))
                    state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
